// File: rtl/list_pkg.sv
// Shared types and defaults for the toggle-handshake list reader.
// The state enum is visible on the reader's dbg_state port.
package list_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_W       = 8;
  localparam int DEF_SUM_W   = 16;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_MAX_LEN = 255;
  localparam int DEF_TIMEOUT = 1024;

  // Handshake rule for the reader:
  // - `req` is a toggle. Each change of `req` asks the producer for one more item.
  // - The producer answers by making `ack` equal to `req`.
  // - While `ack == req`, the answer is on `eol`/`value`. It stays there until the
  //   reader toggles `req` again.
  function automatic logic response_present(input logic req, input logic ack);
    return req == ack;
  endfunction

endpackage

// File: rtl/list_accumulator.sv
// Running fold of list elements: wrapping sum, element count and maximum.
// `last` is high when the next accepted element will bring the count up to MAX_LEN.
module list_accumulator
  import list_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int SUM_W   = DEF_SUM_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [W-1:0]     value,
  output logic [SUM_W-1:0] sum,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     max_val,
  output logic             last
);

  assign last = (count == CNT_W'(MAX_LEN - 1));

  // fold one element per enable; clear wins over enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= '0;
      count   <= '0;
      max_val <= '0;
    end else if (clear) begin
      sum     <= '0;
      count   <= '0;
      max_val <= '0;
    end else if (en) begin
      sum   <= sum + SUM_W'(value);
      count <= count + CNT_W'(1);
      if (value > max_val) max_val <= value;
    end
  end

endmodule

// File: rtl/list_fold_reader.sv
// Consumer end of a toggle-handshake list stream.
// It enables the producer and pulls elements one at a time. It folds them into
// sum/count/max and raises `done` at end of list or when MAX_LEN elements are read.
// Optional watchdog: define LIST_READER_TIMEOUT_EN to abort a request that gets
// no answer within TIMEOUT cycles. The abort sets `error`.
module list_fold_reader
  import list_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int SUM_W   = DEF_SUM_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             start,
  output logic             list_ready,
  output logic             req,
  input  logic             ack,
  input  logic             eol,
  input  logic [W-1:0]     value,
  output logic             done,
  output logic             truncated,
  output logic             error,
  output logic [SUM_W-1:0] sum,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     max_val,
  output state_t           dbg_state
);

  state_t state, state_nxt;
  logic   start_q;
  logic   start_rise;
  logic   resp;
  logic   take;
  logic   acc_last;
  logic   acc_clear;
  logic   acc_en;
  logic   timeout_hit;
  logic   req_nxt;
  logic   done_nxt;
  logic   trunc_nxt;

  assign start_rise = start & ~start_q;
  assign resp       = response_present(req, ack);
  assign take       = (state == WAIT) & resp & ~eol;
  assign dbg_state  = state;

  list_accumulator #(
    .W       (W),
    .SUM_W   (SUM_W),
    .CNT_W   (CNT_W),
    .MAX_LEN (MAX_LEN)
  ) u_acc (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .clear   (acc_clear),
    .en      (acc_en),
    .value   (value),
    .sum     (sum),
    .count   (count),
    .max_val (max_val),
    .last    (acc_last)
  );

  // state register plus the previous start level used for edge detection
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
    end
  end

  // next state: a response ends the read on eol or at the MAX_LEN-th element
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_rise) state_nxt = ARM;
      ARM:     state_nxt = WAIT;
      WAIT: begin
        if (resp) begin
          if (eol || acc_last) state_nxt = DONE;
        end else if (timeout_hit) begin
          state_nxt = DONE;
        end
      end
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs: the producer enable, accumulator control and next values of the registered flags
  always_comb begin
    list_ready = (state == ARM) || (state == WAIT);
    acc_clear  = (state == IDLE) && start_rise;
    acc_en     = take;
    req_nxt    = req;
    done_nxt   = done;
    trunc_nxt  = truncated;
    case (state)
      IDLE: begin
        req_nxt = 1'b0;
        if (start_rise) begin
          done_nxt  = 1'b0;
          trunc_nxt = 1'b0;
        end
      end
      ARM:  req_nxt = 1'b1;
      WAIT: begin
        if (resp) begin
          if (eol) begin
            req_nxt  = 1'b0;
            done_nxt = 1'b1;
          end else if (acc_last) begin
            req_nxt   = 1'b0;
            done_nxt  = 1'b1;
            trunc_nxt = 1'b1;
          end else begin
            // ask for the next element in the same cycle as the fold
            req_nxt = ~req;
          end
        end else if (timeout_hit) begin
          req_nxt  = 1'b0;
          done_nxt = 1'b1;
        end
      end
      DONE:    req_nxt = 1'b0;
      default: req_nxt = 1'b0;
    endcase
  end

  // registered handshake and status outputs
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      req       <= 1'b0;
      done      <= 1'b0;
      truncated <= 1'b0;
    end else begin
      req       <= req_nxt;
      done      <= done_nxt;
      truncated <= trunc_nxt;
    end
  end

`ifdef LIST_READER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  assign timeout_hit = (state == WAIT) && !resp && (wd_cnt == WD_W'(TIMEOUT - 1));

  // watchdog: restarts with every answered request, counts unanswered WAIT cycles
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      wd_cnt <= '0;
    end else if (state != WAIT || resp) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  // error flag: cleared by a new read, set by a watchdog abort
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      error <= 1'b0;
    end else if (acc_clear) begin
      error <= 1'b0;
    end else if (timeout_hit) begin
      error <= 1'b1;
    end
  end
`else
  // No watchdog in this build: WAIT can last forever and TIMEOUT has no effect.
  assign timeout_hit = 1'b0 & (TIMEOUT != 0);
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_list_fold_reader.sv
// Bench for list_fold_reader.
// - u0 uses the default widths and MAX_LEN.
// - u1 has SUM_W=8 and MAX_LEN=2, for the wrap and truncation cases.
// - Each instance has its own behavioural list producer.
// - Expected results come from vector constants or from a plain fold over the element list.
module tb_list_fold_reader;
  import list_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  start = '0;
  logic [1:0]  list_ready, req, done, truncated, error;
  logic [1:0]  ack, eol;
  logic [7:0]  value [2];
  logic [15:0] sum0;
  logic [7:0]  sum1;
  logic [7:0]  count [2];
  logic [7:0]  max_val [2];
  state_t      dbg0, dbg1;

  // producer model state
  logic [7:0] pmem [2][8];
  int         plen [2];
  int         pidx [2];
  int         pwait [2];
  int         cur_lat [2];
  int         plat_max [2];
  bit         mute [2];
  int         resp_cnt [2];

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         g;
    int         len;
    logic [7:0] el [8];
    int         lat;
    int         e_sum;
    int         e_cnt;
    int         e_max;
    bit         e_tr;
    int         e_resp;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  list_fold_reader #(.W(8), .SUM_W(16), .CNT_W(8), .MAX_LEN(255), .TIMEOUT(16)) u0 (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start[0]), .list_ready(list_ready[0]),
    .req(req[0]), .ack(ack[0]), .eol(eol[0]), .value(value[0]), .done(done[0]),
    .truncated(truncated[0]), .error(error[0]), .sum(sum0), .count(count[0]),
    .max_val(max_val[0]), .dbg_state(dbg0)
  );

  list_fold_reader #(.W(8), .SUM_W(8), .CNT_W(8), .MAX_LEN(2), .TIMEOUT(16)) u1 (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start[1]), .list_ready(list_ready[1]),
    .req(req[1]), .ack(ack[1]), .eol(eol[1]), .value(value[1]), .done(done[1]),
    .truncated(truncated[1]), .error(error[1]), .sum(sum1), .count(count[1]),
    .max_val(max_val[1]), .dbg_state(dbg1)
  );

  // list producer: answers each req toggle after a random delay and walks its element list
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= '0;
      eol <= '0;
      for (int g = 0; g < 2; g++) begin
        value[g]   <= '0;
        pidx[g]    <= 0;
        pwait[g]   <= 0;
        cur_lat[g] <= 0;
        resp_cnt[g] <= 0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (!list_ready[g]) begin
          ack[g]     <= 1'b0;
          pidx[g]    <= 0;
          pwait[g]   <= 0;
          cur_lat[g] <= $urandom_range(plat_max[g], 0);
        end else if (req[g] != ack[g] && !mute[g]) begin
          if (pwait[g] < cur_lat[g]) begin
            pwait[g] <= pwait[g] + 1;
          end else begin
            ack[g]      <= req[g];
            resp_cnt[g] <= resp_cnt[g] + 1;
            pwait[g]    <= 0;
            cur_lat[g]  <= $urandom_range(plat_max[g], 0);
            if (pidx[g] < plen[g]) begin
              value[g] <= pmem[g][pidx[g]];
              eol[g]   <= 1'b0;
              pidx[g]  <= pidx[g] + 1;
            end else begin
              value[g] <= 8'($urandom);
              eol[g]   <= 1'b1;
            end
          end
        end
      end
    end
  end

  function automatic int get_sum(input int g);
    return (g == 0) ? int'(sum0) : int'(sum1);
  endfunction

  function automatic state_t get_state(input int g);
    return (g == 0) ? dbg0 : dbg1;
  endfunction

  task automatic check(input string tag, input string what, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0d, expected %0d", tag, what, act, exp);
    end
  endtask

  task automatic load_list(input int g, input int len, input logic [7:0] el [8]);
    for (int i = 0; i < 8; i++) pmem[g][i] = el[i];
    plen[g] = len;
  endtask

  // reference fold: at most the instance's MAX_LEN elements, sum modulo the instance's sum width
  task automatic model(input int g, input int len, input logic [7:0] el [8],
                       output int s, output int c, output int m, output bit tr, output int r);
    int lim;
    int modv;
    lim  = (g == 0) ? 255 : 2;
    modv = (g == 0) ? 65536 : 256;
    s = 0; c = 0; m = 0;
    for (int i = 0; i < len; i++) begin
      if (c < lim) begin
        s = (s + int'(el[i])) % modv;
        c = c + 1;
        if (int'(el[i]) > m) m = int'(el[i]);
      end
    end
    tr = (c == lim);
    r  = tr ? lim : len + 1;
  endtask

  task automatic run_read(input int g, input int lat_max, input bit drop_early,
                          input int e_sum, input int e_cnt, input int e_max,
                          input bit e_tr, input int e_resp, input string tag);
    int r0;
    int cyc;
    bit got;
    plat_max[g] = lat_max;
    r0 = resp_cnt[g];
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    if (drop_early) start[g] = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 500) begin
      if (get_state(g) == WAIT && req[g] == ack[g] && eol[g]) begin
        @(negedge clk);
        check(tag, "done_after_eol", int'(done[g]), 1);
        check(tag, "ready_low_after_eol", int'(list_ready[g]), 0);
        got = 1'b1;
      end else if (done[g]) begin
        got = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!got) check(tag, "done_within_budget", 0, 1);
    check(tag, "sum", get_sum(g), e_sum);
    check(tag, "count", int'(count[g]), e_cnt);
    check(tag, "max_val", int'(max_val[g]), e_max);
    check(tag, "truncated", int'(truncated[g]), int'(e_tr));
    check(tag, "error", int'(error[g]), 0);
    check(tag, "responses", resp_cnt[g] - r0, e_resp);
    start[g] = 1'b0;
    repeat (2) @(negedge clk);
    check(tag, "back_to_idle", int'(get_state(g)), int'(IDLE));
    check(tag, "done_held", int'(done[g]), 1);
    check(tag, "sum_held", get_sum(g), e_sum);
  endtask

  initial begin
    int s, c, m, r, len, g, lat;
    bit tr;
    logic [7:0] el [8];
    logic [7:0] five [8];
    logic [7:0] tl [8];
    string tag;

    for (int i = 0; i < 2; i++) begin
      plen[i] = 0; plat_max[i] = 0; mute[i] = 1'b0;
      for (int k = 0; k < 8; k++) pmem[i][k] = '0;
    end

    vecs[0] = '{g:0, len:3, el:'{8'd2, 8'd12, 8'd30, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, lat:0,
                e_sum:44, e_cnt:3, e_max:30, e_tr:1'b0, e_resp:4};
    vecs[1] = '{g:0, len:0, el:'{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, lat:1,
                e_sum:0, e_cnt:0, e_max:0, e_tr:1'b0, e_resp:1};
    vecs[2] = '{g:0, len:4, el:'{8'd255, 8'd255, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, lat:2,
                e_sum:511, e_cnt:4, e_max:255, e_tr:1'b0, e_resp:5};
    vecs[3] = '{g:1, len:3, el:'{8'd2, 8'd12, 8'd30, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, lat:0,
                e_sum:14, e_cnt:2, e_max:12, e_tr:1'b1, e_resp:2};
    vecs[4] = '{g:1, len:2, el:'{8'd200, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, lat:1,
                e_sum:44, e_cnt:2, e_max:200, e_tr:1'b1, e_resp:2};
    vecs[5] = '{g:1, len:1, el:'{8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, lat:0,
                e_sum:7, e_cnt:1, e_max:7, e_tr:1'b0, e_resp:2};
    vecs[6] = '{g:1, len:0, el:'{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, lat:3,
                e_sum:0, e_cnt:0, e_max:0, e_tr:1'b0, e_resp:1};

    // reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset", "list_ready", int'(list_ready[i]), 0);
      check("reset", "req", int'(req[i]), 0);
      check("reset", "done", int'(done[i]), 0);
      check("reset", "count", int'(count[i]), 0);
    end
    check("reset", "sum0", int'(sum0), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven vectors
    for (int v = 0; v < 7; v++) begin
      load_list(vecs[v].g, vecs[v].len, vecs[v].el);
      run_read(vecs[v].g, vecs[v].lat, 1'b0, vecs[v].e_sum, vecs[v].e_cnt, vecs[v].e_max,
               vecs[v].e_tr, vecs[v].e_resp, $sformatf("vec%0d", v));
    end

    // start/list_ready/req timing and zero dead cycles between elements
    tl = '{8'd2, 8'd12, 8'd30, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    load_list(0, 3, tl);
    plat_max[0] = 0;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    check("timing", "ready_at_n1", int'(list_ready[0]), 1);
    check("timing", "req_low_at_n1", int'(req[0]), 0);
    @(negedge clk);
    check("timing", "req_at_n2", int'(req[0]), 1);
    begin
      int cyc = 0;
      while (!(dbg0 == WAIT && req[0] == ack[0]) && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      check("timing", "first_resp_within_budget", int'(cyc < 50), 1);
      @(negedge clk);
      check("timing", "req_toggles_next_cycle", int'(req[0]), 0);
      check("timing", "count_after_first", int'(count[0]), 1);
      cyc = 0;
      while (!done[0] && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      check("timing", "sum", int'(sum0), 44);
    end
    start[0] = 1'b0;
    repeat (2) @(negedge clk);

    // start dropped mid-read: read still completes
    load_list(0, 3, tl);
    run_read(0, 2, 1'b1, 44, 3, 30, 1'b0, 4, "drop_start");

    // async reset mid-read, then a clean re-read
    five = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd0, 8'd0, 8'd0};
    load_list(0, 5, five);
    plat_max[0] = 1;
    @(negedge clk);
    start[0] = 1'b1;
    begin
      int cyc = 0;
      while (count[0] != 8'd2 && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      check("midreset", "reached_two", int'(count[0]), 2);
    end
    #2;
    rst_n = 1'b0;
    start[0] = 1'b0;
    #1;
    check("midreset", "done", int'(done[0]), 0);
    check("midreset", "list_ready", int'(list_ready[0]), 0);
    check("midreset", "req", int'(req[0]), 0);
    check("midreset", "sum", int'(sum0), 0);
    check("midreset", "count", int'(count[0]), 0);
    check("midreset", "max_val", int'(max_val[0]), 0);
    check("midreset", "truncated", int'(truncated[0]), 0);
    check("midreset", "error", int'(error[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_read(0, 1, 1'b0, 150, 5, 50, 1'b0, 6, "after_reset");

`ifdef LIST_READER_TIMEOUT_EN
    // producer never answers: abort exactly TIMEOUT cycles after the req toggle
    load_list(0, 3, tl);
    mute[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b1;
    begin
      int cyc = 0;
      while (!req[0] && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      check("timeout", "req_raised", int'(req[0]), 1);
    end
    repeat (15) @(negedge clk);
    check("timeout", "no_error_at_15", int'(error[0]), 0);
    @(negedge clk);
    check("timeout", "error_at_16", int'(error[0]), 1);
    check("timeout", "done_at_16", int'(done[0]), 1);
    check("timeout", "count", int'(count[0]), 0);
    start[0] = 1'b0;
    mute[0] = 1'b0;
    repeat (3) @(negedge clk);
`endif

    // randomized lists against the reference fold
    for (int it = 0; it < 24; it++) begin
      g   = $urandom_range(1, 0);
      len = $urandom_range(8, 0);
      lat = $urandom_range(3, 0);
      for (int k = 0; k < 8; k++) el[k] = 8'($urandom);
      load_list(g, len, el);
      model(g, len, el, s, c, m, tr, r);
      tag = $sformatf("rand%0d_u%0d", it, g);
      run_read(g, lat, 1'($urandom_range(1, 0)), s, c, m, tr, r, tag);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
